// File: rtl/qbus_slave_regs.sv
// QBUS target for a small block of I/O-page word registers. It sits on the Z/R/T side of the
// QSIC bus driver, sequences the Am2908 controls and offers a strobe interface to a register file.
`timescale 1ns/1ps
module qbus_slave_regs #(
  parameter logic [12:0] BASE_ADDR = 13'o12150,
  parameter int unsigned NREGS     = 4,
  parameter int unsigned RPLY_DLY  = 2
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        RSYNC,
  input  logic        RDIN,
  input  logic        RDOUT,
  input  logic        RINIT,
  inout  wire  [21:0] ZDAL,
  input  logic        ZBS7,
  input  logic        ZWTBT,
  output logic        DALtx,
  output logic        DALst,
  output logic        DALbe_L,
  output logic        TRPLY,
  output logic [2:0]  reg_sel,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr,
  output logic [15:0] reg_wdata,
  output logic [1:0]  reg_wbe
);

  localparam int unsigned DAL_W  = 22;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned WADR_W = 12;
  localparam int unsigned CNT_W  = (RPLY_DLY > 1) ? $clog2(RPLY_DLY) : 1;

  typedef enum logic [3:0] {
    IDLE, WAIT_END, SEL,
    RD_LOAD, RD_LATCH, RD_STROBE, RD_DRIVE, RD_RPLY, RD_END,
    WR, WR_RPLY
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] sync_q, din_q, dout_q, init_q;
  logic       sync_prev_q;
  logic [DATA_W-1:0] dal_p1_q, dal_p2_q;
  logic [1:0] bs7_q, wtbt_q;

  logic sync_s, din_s, dout_s, init_s, sync_rise;
  logic [WADR_W-1:0] addr_off;
  logic [IDX_W-1:0]  addr_idx;
  logic              addr_match;
  logic              in_xfer;

  logic daltx_q, daltx_d, dalst_q, dalst_d, dalbe_l_q, dalbe_l_d, trply_q, trply_d;
  logic rd_q, rd_d, wr_q, wr_d, odd_q, odd_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, drv_data;
  logic [1:0]        wbe_q, wbe_d;
  logic              unused_dal_hi;

  // Bus strobes through 2-flop synchronizers; DAL/BS7/WTBT delayed by the same two stages.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sync_q      <= '0;
      din_q       <= '0;
      dout_q      <= '0;
      init_q      <= '0;
      sync_prev_q <= 1'b0;
      dal_p1_q    <= '0;
      dal_p2_q    <= '0;
      bs7_q       <= '0;
      wtbt_q      <= '0;
    end else begin
      sync_q      <= {sync_q[0], RSYNC};
      din_q       <= {din_q[0], RDIN};
      dout_q      <= {dout_q[0], RDOUT};
      init_q      <= {init_q[0], RINIT};
      sync_prev_q <= sync_q[1];
      dal_p1_q    <= ZDAL[DATA_W-1:0];
      dal_p2_q    <= dal_p1_q;
      bs7_q       <= {bs7_q[0], ZBS7};
      wtbt_q      <= {wtbt_q[0], ZWTBT};
    end
  end

  assign sync_s    = sync_q[1];
  assign din_s     = din_q[1];
  assign dout_s    = dout_q[1];
  assign init_s    = init_q[1];
  assign sync_rise = sync_s & ~sync_prev_q;

  // Word offset from register 0; addresses below the base wrap to large values and miss.
  assign addr_off   = dal_p2_q[WADR_W:1] - BASE_ADDR[12:1];
  assign addr_idx   = IDX_W'(addr_off[IDX_W-1:0] & IDX_W'(NREGS - 1));
  assign addr_match = bs7_q[1] && (addr_off < WADR_W'(NREGS));

  assign in_xfer = (state_q == RD_LOAD) || (state_q == RD_LATCH) || (state_q == RD_STROBE) ||
                   (state_q == RD_DRIVE) || (state_q == RD_RPLY) || (state_q == RD_END) ||
                   (state_q == WR) || (state_q == WR_RPLY);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (init_s) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:      if (sync_rise) state_d = addr_match ? SEL : WAIT_END;
      WAIT_END:  if (!sync_s) state_d = IDLE;
      SEL: begin
        if (!sync_s)     state_d = IDLE;
        else if (din_s)  state_d = RD_LOAD;
        else if (dout_s) state_d = WR;
      end
      RD_LOAD:   state_d = RD_LATCH;
      RD_LATCH:  state_d = RD_STROBE;
      RD_STROBE: begin
        state_d = RD_DRIVE;
        cnt_d   = '0;
      end
      RD_DRIVE: begin
        if (cnt_q == CNT_W'(RPLY_DLY - 1)) state_d = RD_RPLY;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      RD_RPLY:   if (!din_s) state_d = RD_END;
      RD_END:    state_d = SEL;
      WR:        state_d = WR_RPLY;
      WR_RPLY:   if (!dout_s) state_d = SEL;
      default:   state_d = IDLE;
    endcase
    // Master dropped SYNC mid-transfer: release the bus at once.
    if (in_xfer && !sync_s) state_d = IDLE;
  end

  always_comb begin
    sel_d   = sel_q;
    odd_d   = odd_q;
    wdata_d = wdata_q;
    wbe_d   = wbe_q;
    rdata_d = rdata_q;
    if ((state_q == IDLE) && sync_rise && addr_match) begin
      sel_d = addr_idx;
      odd_d = dal_p2_q[0];
    end
    if ((state_d == WR) && (state_q != WR)) begin
      wdata_d = dal_p2_q;
      wbe_d   = !wtbt_q[1] ? 2'b11 : (odd_q ? 2'b10 : 2'b01);
    end
    if (state_q == RD_LATCH) rdata_d = reg_rdata;
    daltx_d   = (state_d == RD_LATCH) || (state_d == RD_STROBE) ||
                (state_d == RD_DRIVE) || (state_d == RD_RPLY);
    dalst_d   = (state_d == RD_STROBE);
    dalbe_l_d = !((state_d == RD_DRIVE) || (state_d == RD_RPLY));
    trply_d   = (state_d == RD_RPLY) || (state_d == WR) || (state_d == WR_RPLY);
    rd_d      = (state_d == RD_LOAD);
    wr_d      = (state_d == WR);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      daltx_q <= 1'b0; dalst_q <= 1'b0; dalbe_l_q <= 1'b1; trply_q <= 1'b0;
      rd_q <= 1'b0; wr_q <= 1'b0; odd_q <= 1'b0;
      sel_q <= '0; wdata_q <= '0; wbe_q <= '0; rdata_q <= '0;
    end else if (init_s) begin
      daltx_q <= 1'b0; dalst_q <= 1'b0; dalbe_l_q <= 1'b1; trply_q <= 1'b0;
      rd_q <= 1'b0; wr_q <= 1'b0; odd_q <= 1'b0;
      sel_q <= '0; wdata_q <= '0; wbe_q <= '0; rdata_q <= '0;
    end else begin
      daltx_q <= daltx_d; dalst_q <= dalst_d; dalbe_l_q <= dalbe_l_d; trply_q <= trply_d;
      rd_q <= rd_d; wr_q <= wr_d; odd_q <= odd_d;
      sel_q <= sel_d; wdata_q <= wdata_d; wbe_q <= wbe_d; rdata_q <= rdata_d;
    end
  end

  // During RD_LATCH the register file output goes straight out, so data is set up before DALst.
  assign drv_data = (state_q == RD_LATCH) ? reg_rdata : rdata_q;
  assign ZDAL     = daltx_q ? {6'b0, drv_data} : {DAL_W{1'bz}};

  assign unused_dal_hi = ^ZDAL[DAL_W-1:DATA_W];

  assign DALtx     = daltx_q;
  assign DALst     = dalst_q;
  assign DALbe_L   = dalbe_l_q;
  assign TRPLY     = trply_q;
  assign reg_sel   = sel_q;
  assign reg_rd    = rd_q;
  assign reg_wr    = wr_q;
  assign reg_wdata = wdata_q;
  assign reg_wbe   = wbe_q;

endmodule

// File: tb/tb_qbus_slave_regs.sv
// Directed bench for qbus_slave_regs: DATI, DATO, DATOB, DATIO, address misses, RINIT and reset.
`timescale 1ns/1ps
module tb_qbus_slave_regs;

  localparam int unsigned RPLY_DLY = 2;

  logic clk = 1'b0, reset_L = 1'b0;
  logic RSYNC = 1'b0, RDIN = 1'b0, RDOUT = 1'b0, RINIT = 1'b0, ZBS7 = 1'b0, ZWTBT = 1'b0;
  wire  [21:0] ZDAL;
  logic tb_drv = 1'b0;
  logic [21:0] tb_zdal = '0;
  logic DALtx, DALst, DALbe_L, TRPLY, reg_rd, reg_wr;
  logic [2:0]  reg_sel;
  logic [15:0] reg_rdata = '0, reg_wdata;
  logic [1:0]  reg_wbe;

  assign ZDAL = tb_drv ? tb_zdal : {22{1'bz}};

  qbus_slave_regs #(.BASE_ADDR(13'o12150), .NREGS(4), .RPLY_DLY(RPLY_DLY)) dut (
    .clk(clk), .reset_L(reset_L), .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT), .RINIT(RINIT),
    .ZDAL(ZDAL), .ZBS7(ZBS7), .ZWTBT(ZWTBT), .DALtx(DALtx), .DALst(DALst), .DALbe_L(DALbe_L),
    .TRPLY(TRPLY), .reg_sel(reg_sel), .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_wbe(reg_wbe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus observer: strobe counts, edge timestamps and control-pin invariants.
  int rd_cnt = 0, wr_cnt = 0, act_cnt = 0, inv_err = 0;
  int t_tx = 0, t_be = 0, t_rply = 0;
  logic [2:0]  rd_sel = '0, wr_sel = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0, rel = '0;
  logic [21:0] zdal_pre = '0;
  logic p_tx = 1'b0, p_be = 1'b1, p_rply = 1'b0;
  always @(negedge clk) begin
    if (reg_rd) begin rd_cnt++; rd_sel = reg_sel; end
    if (reg_wr) begin wr_cnt++; wr_sel = reg_sel; wr_data = reg_wdata; wr_be = reg_wbe; end
    if (reg_rd || reg_wr || TRPLY || DALtx || !DALbe_L) act_cnt++;
    if (!DALbe_L && !DALtx) inv_err++;
    if (DALtx && !p_tx) t_tx = cyc;
    if (!DALbe_L && p_be) t_be = cyc;
    if (TRPLY && !p_rply) t_rply = cyc;
    if (!TRPLY && p_rply) rel = {DALtx, DALbe_L};
    if (DALtx && !DALst && DALbe_L) zdal_pre = ZDAL;
    p_tx = DALtx; p_be = DALbe_L; p_rply = TRPLY;
  end

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_trply(input logic v, input string tag);
    for (int i = 0; i < 64; i++) begin
      if (TRPLY === v) break;
      @(negedge clk);
    end
    check(tag, 32'(TRPLY), 32'(v));
  endtask

  task automatic addr_phase(input logic [12:0] a, input logic bs7);
    @(negedge clk);
    tb_zdal = {9'b0, a}; ZBS7 = bs7; tb_drv = 1'b1; RSYNC = 1'b1;
    idle(5);
    tb_drv = 1'b0; ZBS7 = 1'b0;
  endtask

  task automatic end_cycle();
    RSYNC = 1'b0;
    idle(4);
  endtask

  task automatic do_read(output int lat);
    int t0;
    t0 = cyc; RDIN = 1'b1;
    wait_trply(1'b1, "dati_rply_up");
    idle(1);
    lat = t_rply - t0;
    RDIN = 1'b0;
    wait_trply(1'b0, "dati_rply_down");
  endtask

  task automatic do_write(input logic [15:0] d, input logic wtbt, output int lat);
    int t0;
    tb_zdal = {6'b0, d}; ZWTBT = wtbt; tb_drv = 1'b1;
    t0 = cyc; RDOUT = 1'b1;
    wait_trply(1'b1, "dato_rply_up");
    idle(1);
    lat = t_rply - t0;
    RDOUT = 1'b0;
    wait_trply(1'b0, "dato_rply_down");
    tb_drv = 1'b0; ZWTBT = 1'b0;
  endtask

  initial begin
    int lat, rd0, wr0, a0;
    idle(3);
    check("reset_ctl", 32'({DALtx, DALst, DALbe_L, TRPLY, reg_rd, reg_wr}), 32'(6'b001000));
    check("reset_sel_wbe", 32'({reg_sel, reg_wbe}), 32'd0);
    check("reset_wdata", 32'(reg_wdata), 32'd0);
    reset_L = 1'b1;
    idle(2);

    // DATI to 772152
    reg_rdata = 16'o123456; rd0 = rd_cnt;
    addr_phase(13'o12152, 1'b1);
    do_read(lat);
    end_cycle();
    check("dati_rd_once", 32'(rd_cnt - rd0), 32'd1);
    check("dati_sel", 32'(rd_sel), 32'd1);
    check("dati_zdal_pre_st", 32'(zdal_pre), 32'(22'o0123456));
    check("dati_be_to_rply", 32'(t_rply - t_be), 32'(RPLY_DLY));
    check("dati_tx_to_be", 32'(t_be - t_tx), 32'd2);
    check("dati_release", 32'(rel), 32'(2'b01));
    check("dati_latency", 32'(lat), 32'(2 + 4 + RPLY_DLY));

    // DATO to 772154
    wr0 = wr_cnt;
    addr_phase(13'o12154, 1'b1);
    do_write(16'o177001, 1'b0, lat);
    end_cycle();
    check("dato_wr_once", 32'(wr_cnt - wr0), 32'd1);
    check("dato_sel", 32'(wr_sel), 32'd2);
    check("dato_wdata", 32'(wr_data), 32'(16'o177001));
    check("dato_wbe", 32'(wr_be), 32'(2'b11));
    check("dato_latency", 32'(lat), 32'd3);

    // DATOB odd and even
    addr_phase(13'o12157, 1'b1);
    do_write(16'o125000, 1'b1, lat);
    end_cycle();
    check("datob_odd_wbe", 32'(wr_be), 32'(2'b10));
    check("datob_odd_sel", 32'(wr_sel), 32'd3);
    addr_phase(13'o12156, 1'b1);
    do_write(16'o000252, 1'b1, lat);
    end_cycle();
    check("datob_even_wbe", 32'(wr_be), 32'(2'b01));

    // Misses: past the block, and BS7 low
    a0 = act_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    addr_phase(13'o12160, 1'b1);
    RDIN = 1'b1; idle(20); RDIN = 1'b0;
    end_cycle();
    addr_phase(13'o12150, 1'b0);
    RDOUT = 1'b1; idle(20); RDOUT = 1'b0;
    end_cycle();
    check("miss_activity", 32'(act_cnt - a0), 32'd0);
    check("miss_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
    reg_rdata = 16'o000777; rd0 = rd_cnt;
    addr_phase(13'o12150, 1'b1);
    do_read(lat);
    end_cycle();
    check("after_miss_rd", 32'(rd_cnt - rd0), 32'd1);
    check("after_miss_zdal", 32'(zdal_pre), 32'(22'o0000777));

    // DATIO to 772150
    reg_rdata = 16'o011111; rd0 = rd_cnt; wr0 = wr_cnt;
    addr_phase(13'o12150, 1'b1);
    do_read(lat);
    do_write(16'o052525, 1'b0, lat);
    end_cycle();
    check("datio_counts", 32'({rd_cnt - rd0, wr_cnt - wr0}), {32'd1, 32'd1});
    check("datio_sels", 32'({rd_sel, wr_sel}), 32'd0);
    check("datio_wdata", 32'(wr_data), 32'(16'o052525));

    // RINIT while in RD_RPLY
    addr_phase(13'o12152, 1'b1);
    RDIN = 1'b1;
    wait_trply(1'b1, "rinit_rply_up");
    RINIT = 1'b1;
    idle(3);
    check("rinit_ctl", 32'({DALtx, DALst, DALbe_L, TRPLY, reg_rd, reg_wr}), 32'(6'b001000));
    check("rinit_sel_wbe_wdata", 32'({reg_sel, reg_wbe, reg_wdata}), 32'd0);
    RINIT = 1'b0; RDIN = 1'b0; RSYNC = 1'b0;
    idle(4);
    wr0 = wr_cnt;
    addr_phase(13'o12156, 1'b1);
    do_write(16'o000123, 1'b0, lat);
    end_cycle();
    check("post_rinit_wr", 32'({wr_cnt - wr0}), 32'd1);
    check("post_rinit_data", 32'({wr_sel, wr_be, wr_data}), 32'({3'd3, 2'b11, 16'o000123}));

    // reset_L mid-write
    addr_phase(13'o12154, 1'b1);
    tb_zdal = {6'b0, 16'o033333}; tb_drv = 1'b1; RDOUT = 1'b1;
    wait_trply(1'b1, "rst_rply_up");
    reset_L = 1'b0;
    #1;
    check("rst_ctl", 32'({DALtx, DALst, DALbe_L, TRPLY, reg_rd, reg_wr}), 32'(6'b001000));
    check("rst_sel_wbe_wdata", 32'({reg_sel, reg_wbe, reg_wdata}), 32'd0);
    RDOUT = 1'b0; RSYNC = 1'b0; tb_drv = 1'b0;
    @(negedge clk); reset_L = 1'b1;
    idle(3);
    reg_rdata = 16'o070707; rd0 = rd_cnt;
    addr_phase(13'o12154, 1'b1);
    do_read(lat);
    end_cycle();
    check("post_rst_rd", 32'({rd_cnt - rd0}), 32'd1);
    check("post_rst_sel_zdal", 32'({rd_sel, zdal_pre}), 32'({3'd2, 22'o0070707}));

    check("bus_invariants", 32'(inv_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qbus_slave_regs.md
Name: qbus_slave_regs

Overview:
- FPGA-side QBUS target (responder) for a small block of I/O-page word registers, sitting directly on the positive-logic Z/R/T side of the QSIC bus driver.
- Decodes the address phase and answers DATI, DATO, DATOB and DATIO(B) cycles.
- Sequences the Am2908 controls (DALtx, DALst, DALbe_L) and asserts TRPLY.
- Presents a simple synchronous read/write strobe interface to the device register file.

Parameters:
- BASE_ADDR, 13'o12150: I/O-page offset of register 0. Word aligned; bit 0 must be 0.
- NREGS, 4: number of 16-bit registers. Power of two, 1..8.
- RPLY_DLY, 2: clocks between DALbe_L asserting and TRPLY asserting on DATI (data setup).

Ports:
- clk  in  1  system clock, ≥40 MHz
- reset_L  in  1  asynchronous active-low reset
- RSYNC  in  1  bus SYNC, asynchronous
- RDIN  in  1  bus DIN, asynchronous
- RDOUT  in  1  bus DOUT, asynchronous
- RINIT  in  1  bus INIT, asynchronous
- ZDAL  inout  22  Z-side DAL; driven only while DALtx=1
- ZBS7  in  1  Z-side BS7
- ZWTBT  in  1  Z-side WTBT
- DALtx  out  1  Am2908 direction: 1 = FPGA to bus
- DALst  out  1  Am2908 output latch strobe (rising edge latches)
- DALbe_L  out  1  Am2908 bus enable, active low
- TRPLY  out  1  bus RPLY request
- reg_sel  out  3  register index, addr[3:1] masked to log2(NREGS)
- reg_rd  out  1  one-clock read strobe
- reg_rdata  in  16  register read data, valid the clock after reg_rd
- reg_wr  out  1  one-clock write strobe
- reg_wdata  out  16  write data
- reg_wbe  out  2  byte enables {hi,lo}

Behaviour:
- Reset and RINIT (asynchronous reset; RINIT after a 2-flop synchronizer):
  - Force state IDLE.
  - Outputs: DALtx=0, DALst=0, DALbe_L=1, TRPLY=0, ZDAL=Z, reg_rd=0, reg_wr=0, reg_sel=0, reg_wdata=0, reg_wbe=0.
  - RINIT takes effect mid-cycle too; a pending strobe is dropped.
- Synchronization:
  - RSYNC, RDIN and RDOUT pass through 2-flop synchronizers.
  - ZDAL, ZBS7 and ZWTBT pass through a matching 2-stage register pipeline, so sampled data aligns with the synchronized strobes.
- IDLE: on the synchronized SYNC rising edge, capture the aligned ZDAL[12:0] and ZBS7.
  - Match when ZBS7=1 and addr[12:1] falls in BASE_ADDR[12:1] .. BASE_ADDR[12:1]+NREGS-1.
  - Match goes to SEL with reg_sel and addr[0] stored. No match goes to WAIT_END.
- WAIT_END: never drives anything. Return to IDLE when SYNC negates.
- SEL:
  - SYNC negated goes to IDLE.
  - DIN seen goes to RD_LOAD. DOUT seen goes to WR. DIN has priority if both are seen the same clock.
- Read sequence (DATI):
  - RD_LOAD: reg_rd=1 for one clock.
  - RD_LATCH: DALtx=1; ZDAL={6'b0, reg_rdata}.
  - RD_STROBE: DALst=1 for one clock.
  - RD_DRIVE: DALst=0; DALbe_L=0; count RPLY_DLY clocks.
  - RD_RPLY: TRPLY=1; hold until DIN negates.
  - RD_END: TRPLY=0, DALbe_L=1, DALtx=0, ZDAL=Z in the same clock; go to SEL. This permits DATIO.
- Write sequence (DATO/DATOB):
  - WR: on the DOUT edge, take the aligned ZDAL[15:0] as reg_wdata.
    - ZWTBT=0 gives reg_wbe=2'b11.
    - ZWTBT=1 gives reg_wbe=2'b10 if addr[0]=1, else 2'b01.
    - reg_wr=1 for one clock, then TRPLY=1.
  - WR_RPLY: hold until DOUT negates, then TRPLY=0 and go to SEL.
- SYNC negating during any read/write state (protocol violation):
  - Immediate release: TRPLY=0, DALbe_L=1, DALtx=0, ZDAL=Z.
  - Go to IDLE.
  - A reg_wr already issued is not retracted.
- Latency: from synchronized DIN to TRPLY is 4+RPLY_DLY clocks; from synchronized DOUT to TRPLY is 1 clock.
- DALbe_L=0 only ever while DALtx=1, and DALtx rises at least 2 clocks before DALbe_L falls. ZDAL is never driven while DALtx=0.
- Word register addresses only; byte reads return the full word (the master selects the byte).

Test Plan:
- DATI to 772152 (addr 13'o12152, BS7=1), reg_rdata=16'o123456:
  - reg_rd pulses with reg_sel=1.
  - ZDAL=22'o0123456 before DALst rises.
  - TRPLY rises RPLY_DLY clocks after DALbe_L=0.
  - DIN negate clears TRPLY, DALbe_L and DALtx in one clock.
- DATO to 772154 with ZDAL=16'o177001, WTBT=0 → reg_wr once, reg_sel=2, reg_wdata=16'o177001, reg_wbe=2'b11, TRPLY until DOUT negates.
- DATOB to 772157 (odd), WTBT=1 in data phase → reg_wbe=2'b10, reg_sel=3.
- DATOB to 772156 (even), WTBT=1 → reg_wbe=2'b01.
- Miss cases: address 772160, and address 12150 with BS7=0:
  - No strobes; TRPLY, DALtx and DALbe_L never assert.
  - Next matching cycle is answered normally.
- DATIO to 772150: DIN, RPLY, DIN negates; then DOUT, RPLY, DOUT negates; all within one SYNC → exactly one reg_rd and one reg_wr, both reg_sel=0.
- RINIT during RD_RPLY, and separately reset_L=0 mid-write:
  - All outputs return to reset values within 3 clocks (RINIT) or immediately (reset_L).
  - FSM is in IDLE; the next cycle completes normally.
